pc_fetch_unit: RTL and testbench

- Holds the architectural PC and drives the instruction-memory fetch handshake.
- Feeds the IF/ID instruction register.
- Consumes the word-addressed next-PC from the next-PC calculator; its registered PC/IF-ID PC are the calculator's PC inputs.
- Handles stalls, taken redirects (no delay slot: wrong-path fetch discarded), interrupt entry to the handler vector with EPC capture, and variable-latency IM.

---
 rtl/pc_fetch_unit.sv | 192 +++++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// PC register, instruction-memory fetch handshake and IF/ID register with stall, redirect and interrupt handling.
// Optional FETCH_PERF_CNT_EN adds fetch/wait performance counters.
module pc_fetch_unit #(
  parameter logic [29:0] RESET_PC = 30'h00000C00,
  parameter logic [29:0] EXC_VEC  = 30'h00001060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] npc_in,
  input  logic        redirect,
  input  logic        stall,
  input  logic        int_req,
  output logic        im_req,
  output logic [29:0] im_addr,
  input  logic        im_ready,
  input  logic [31:0] im_rdata,
  output logic [29:0] pc,
  output logic [29:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic [29:0] epc_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] wait_cnt
`endif
);

  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] if_pc_q, if_pc_d;
  logic [DW-1:0] if_instr_q, if_instr_d;
  logic          if_valid_q, if_valid_d;
  logic [AW-1:0] epc_q, epc_d;
  logic [DW-1:0] buf_q, buf_d;
  logic [AW-1:0] tgt_q, tgt_d;
  logic          im_req_q, im_req_d;

  logic          evt_c;
  logic [AW-1:0] target_c;
  logic          load_c;
  logic [DW-1:0] load_instr_c;

  // Next-state and datapath: interrupt beats redirect beats normal sequencing.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    if_valid_d   = if_valid_q;
    epc_d        = epc_q;
    buf_d        = buf_q;
    tgt_d        = tgt_q;
    evt_c        = 1'b0;
    target_c     = npc_in;
    load_c       = 1'b0;
    load_instr_c = im_rdata;

    if (state_q != IDLE) begin
      if (int_req) begin
        evt_c    = 1'b1;
        target_c = EXC_VEC;
        epc_d    = if_valid_q ? if_pc_q : pc_q;
      end else if (redirect && !stall) begin
        evt_c = 1'b1;
      end
    end

    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (evt_c) begin
          if_valid_d = 1'b0;
          if (im_ready) begin
            pc_d = target_c;
          end else begin
            tgt_d   = target_c;
            state_d = DRAIN;
          end
        end else if (im_ready && !stall) begin
          load_c = 1'b1;
        end else if (im_ready && stall) begin
          buf_d   = im_rdata;
          state_d = HOLD;
        end else if (!im_ready && !stall) begin
          if_valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (evt_c) begin
          if_valid_d = 1'b0;
          pc_d       = target_c;
          state_d    = FETCH;
        end else if (!stall) begin
          load_c       = 1'b1;
          load_instr_c = buf_q;
          state_d      = FETCH;
        end
      end
      DRAIN: begin
        if (evt_c) begin
          if_valid_d = 1'b0;
          tgt_d      = target_c;
        end
        // A target arriving in the same cycle as the stale word wins over the latched one.
        if (im_ready) begin
          pc_d    = evt_c ? target_c : tgt_q;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_c) begin
      if_instr_d = load_instr_c;
      if_pc_d    = pc_q;
      if_valid_d = 1'b1;
      pc_d       = pc_q + AW'(1);
    end

    im_req_d = (state_d == FETCH) || (state_d == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      if_valid_q <= 1'b0;
      epc_q      <= '0;
      buf_q      <= '0;
      tgt_q      <= '0;
      im_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      epc_q      <= epc_d;
      buf_q      <= buf_d;
      tgt_q      <= tgt_d;
      im_req_q   <= im_req_d;
    end
  end

  assign im_req   = im_req_q;
  assign im_addr  = pc_q;
  assign pc       = pc_q;
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;
  assign if_valid = if_valid_q;
  assign epc_out  = epc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;

  // Delivered instructions and IM wait cycles, both free-running modulo 2^32.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    if (load_c) fetch_cnt_d = fetch_cnt_q + 32'(1);
    if (im_req_q && !im_ready) wait_cnt_d = wait_cnt_q + 32'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign wait_cnt  = wait_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequencing, IM waits, stall/HOLD, redirect/DRAIN, interrupts, wrap and reset.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst;
  logic [29:0] npc_in;
  logic        redirect;
  logic        stall;
  logic        int_req;
  logic        im_req;
  logic [29:0] im_addr;
  logic        im_ready;
  logic [31:0] im_rdata;
  logic [29:0] pc;
  logic [29:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic [29:0] epc_out;

  int checks;
  int errors;

  pc_fetch_unit dut (
    .clk      (clk),
    .rst      (rst),
    .npc_in   (npc_in),
    .redirect (redirect),
    .stall    (stall),
    .int_req  (int_req),
    .im_req   (im_req),
    .im_addr  (im_addr),
    .im_ready (im_ready),
    .im_rdata (im_rdata),
    .pc       (pc),
    .if_pc    (if_pc),
    .if_instr (if_instr),
    .if_valid (if_valid),
    .epc_out  (epc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory content: tagged copy of the word address.
  function automatic logic [31:0] instr_of(input logic [29:0] a);
    return {2'b11, a};
  endfunction

  assign im_rdata = instr_of(im_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    npc_in   = '0;
    redirect = 1'b0;
    stall    = 1'b0;
    int_req  = 1'b0;
    im_ready = 1'b0;

    cycle();
    check("rst_pc", 32'(pc), 32'h0000_0C00);
    check("rst_im_req", 32'(im_req), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc", 32'(if_pc), 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_epc", 32'(epc_out), 32'd0);

    // Zero-wait sequencing
    rst      = 1'b1;
    im_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("seq_im_req", 32'(im_req), 32'd1);
      check("seq_im_addr", 32'(im_addr), 32'h0C00 + 32'(i));
      if (i > 0) begin
        check("seq_if_valid", 32'(if_valid), 32'd1);
        check("seq_if_pc", 32'(if_pc), 32'h0C00 + 32'(i - 1));
        check("seq_if_instr", if_instr, 32'hC000_0C00 + 32'(i - 1));
      end else begin
        check("seq_first_if_valid", 32'(if_valid), 32'd0);
      end
    end

    // IM wait states at 0xC03
    im_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("wait_im_addr", 32'(im_addr), 32'h0C03);
      check("wait_im_req", 32'(im_req), 32'd1);
      check("wait_if_valid", 32'(if_valid), 32'd0);
    end
    im_ready = 1'b1;
    cycle();
    check("wait_done_if_pc", 32'(if_pc), 32'h0C03);
    check("wait_done_instr", if_instr, 32'hC000_0C03);
    check("wait_done_pc", 32'(pc), 32'h0C04);

    // Stall while IM returns 0xC04 -> HOLD
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("hold_im_req", 32'(im_req), 32'd0);
      check("hold_if_pc", 32'(if_pc), 32'h0C03);
      check("hold_if_valid", 32'(if_valid), 32'd1);
      check("hold_pc", 32'(pc), 32'h0C04);
    end
    stall = 1'b0;
    cycle();
    check("unhold_if_pc", 32'(if_pc), 32'h0C04);
    check("unhold_instr", if_instr, 32'hC000_0C04);
    check("unhold_im_addr", 32'(im_addr), 32'h0C05);
    check("unhold_im_req", 32'(im_req), 32'd1);

    // Redirect under stall is ignored
    redirect = 1'b1;
    npc_in   = 30'h0D00;
    stall    = 1'b1;
    im_ready = 1'b0;
    cycle();
    check("rd_stall_pc", 32'(pc), 32'h0C05);
    check("rd_stall_if_valid", 32'(if_valid), 32'd1);
    check("rd_stall_if_pc", 32'(if_pc), 32'h0C04);
    // Accepted redirect without im_ready -> DRAIN
    stall = 1'b0;
    cycle();
    check("drain_im_addr", 32'(im_addr), 32'h0C05);
    check("drain_im_req", 32'(im_req), 32'd1);
    check("drain_if_valid", 32'(if_valid), 32'd0);
    redirect = 1'b0;
    cycle();
    check("drain2_im_addr", 32'(im_addr), 32'h0C05);
    im_ready = 1'b1;
    cycle();
    check("drain_exit_pc", 32'(pc), 32'h0D00);
    check("drain_exit_if_valid", 32'(if_valid), 32'd0);
    check("drain_exit_if_instr", if_instr, 32'hC000_0C04);
    cycle();
    check("post_rd_if_pc", 32'(if_pc), 32'h0D00);
    check("post_rd_if_valid", 32'(if_valid), 32'd1);
    cycle();
    check("post_rd2_if_pc", 32'(if_pc), 32'h0D01);
    check("post_rd2_pc", 32'(pc), 32'h0D02);

    // Interrupt with a valid IF/ID instruction
    int_req = 1'b1;
    cycle();
    int_req = 1'b0;
    check("int_epc", 32'(epc_out), 32'h0D01);
    check("int_if_valid", 32'(if_valid), 32'd0);
    check("int_im_addr", 32'(im_addr), 32'h1060);
    cycle();
    check("int_handler_if_pc", 32'(if_pc), 32'h1060);
    check("int_handler_pc", 32'(pc), 32'h1061);

    // Interrupt and redirect together: interrupt wins
    int_req  = 1'b1;
    redirect = 1'b1;
    npc_in   = 30'h0D00;
    cycle();
    int_req  = 1'b0;
    redirect = 1'b0;
    check("int_rd_pc", 32'(pc), 32'h1060);
    check("int_rd_epc", 32'(epc_out), 32'h1060);
    cycle();
    check("int_rd_next_pc", 32'(pc), 32'h1061);

    // Interrupt with empty IF/ID captures pc, then reset mid-DRAIN
    im_ready = 1'b0;
    cycle();
    check("bubble_if_valid", 32'(if_valid), 32'd0);
    int_req = 1'b1;
    cycle();
    int_req = 1'b0;
    check("int_nv_epc", 32'(epc_out), 32'h1061);
    check("int_nv_im_addr", 32'(im_addr), 32'h1061);
    check("int_nv_im_req", 32'(im_req), 32'd1);
    rst = 1'b0;
    cycle();
    check("rst_drain_pc", 32'(pc), 32'h0C00);
    check("rst_drain_im_req", 32'(im_req), 32'd0);
    check("rst_drain_if_valid", 32'(if_valid), 32'd0);
    check("rst_drain_epc", 32'(epc_out), 32'd0);
    rst      = 1'b1;
    im_ready = 1'b1;
    cycle();
    check("restart_im_req", 32'(im_req), 32'd1);
    check("restart_im_addr", 32'(im_addr), 32'h0C00);

    // PC wrap at the top of the word address space
    redirect = 1'b1;
    npc_in   = 30'h3FFF_FFFF;
    cycle();
    redirect = 1'b0;
    check("wrap_pc_top", 32'(pc), 32'h3FFF_FFFF);
    cycle();
    check("wrap_if_pc", 32'(if_pc), 32'h3FFF_FFFF);
    check("wrap_pc_zero", 32'(pc), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
